// File: rtl/fft_seq_pkg.sv
// Shared frame geometry, FSM state encoding and ping-pong buffer select for the FFT frame sequencer.
package fft_seq_pkg;
  localparam int N_POINTS = 16;
  localparam int SAMPLE_W = 24;
  localparam int PTR_W    = $clog2(N_POINTS);
  localparam int FRAME_W  = N_POINTS * SAMPLE_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    CAPTURE
  } seq_state_t;

  typedef enum logic {
    BUF_A = 1'b0,
    BUF_B = 1'b1
  } buf_sel_t;

  function automatic buf_sel_t other_buf(input buf_sel_t s);
    return (s == BUF_A) ? BUF_B : BUF_A;
  endfunction
endpackage

// File: rtl/frame_pingpong_buf.sv
// Ping-pong frame collector: two N_POINTS-sample buffers, oldest-full-first read side.
// Latency: buffer marked full on the edge that writes its last sample; frame readable next cycle.
// Backpressure: none upstream; samples arriving while the fill buffer is still full are dropped and counted.
import fft_seq_pkg::*;

module frame_pingpong_buf (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                sample_vld,
  input  logic [SAMPLE_W-1:0] sample_dat,
  input  logic                free_vld,
  output logic                rd_vld,
  output logic [FRAME_W-1:0]  rd_dat,
  output logic [15:0]         overflow_count
);
  logic [SAMPLE_W-1:0] mem [2][N_POINTS];
  logic [1:0]          full;
  logic [PTR_W-1:0]    ptr;
  buf_sel_t            fill_sel;
  buf_sel_t            rd_sel;
  logic                wr_en;
  logic                drop;

  assign wr_en  = enable && sample_vld && !full[fill_sel];
  assign drop   = enable && sample_vld &&  full[fill_sel];
  assign rd_vld = |full;

  // fill_sel always points at the buffer completed least recently, so if it is
  // still full it holds the older of two frames; otherwise the other one is the only full frame.
  assign rd_sel = full[fill_sel] ? fill_sel : other_buf(fill_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full           <= '0;
      ptr            <= '0;
      fill_sel       <= BUF_A;
      overflow_count <= '0;
    end else begin
      if (free_vld)
        full[rd_sel] <= 1'b0;
      if (!enable) begin
        ptr <= '0;
      end else if (wr_en) begin
        if (ptr == PTR_W'(N_POINTS - 1)) begin
          full[fill_sel] <= 1'b1;
          ptr            <= '0;
          fill_sel       <= other_buf(fill_sel);
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
      if (drop && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[fill_sel][ptr] <= sample_dat;
  end

  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < N_POINTS; k++)
      rd_dat[k*SAMPLE_W +: SAMPLE_W] = mem[rd_sel][k];
  end
endmodule

// File: rtl/fft_frame_sequencer.sv
// Feeds full audio frames to the 16-point FFT and latches its bins; optional watchdog via FFT_WATCHDOG_EN.
// Latency: fft_start 2 cycles after the last frame sample is written; bins_out 1 cycle after fft_done.
// Backpressure: one frame in flight; up to two frames queued, further samples dropped and counted.
import fft_seq_pkg::*;

module fft_frame_sequencer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [FRAME_W-1:0]  fft_samples,
  output logic                fft_start,
  input  logic                fft_done,
  input  logic [FRAME_W-1:0]  fft_bins,
  output logic [FRAME_W-1:0]  bins_out,
  output logic                bins_valid,
  output logic                busy,
  output logic [15:0]         overflow_count,
  output logic                fft_error
);
  seq_state_t         state;
  logic               rd_vld;
  logic [FRAME_W-1:0] rd_dat;
  logic               wd_expire;

  frame_pingpong_buf u_buf (
    .clk            (Clk),
    .rst_n          (Reset_n),
    .enable         (enable),
    .sample_vld     (sample_valid),
    .sample_dat     (sample_data),
    .free_vld       (state == LOAD),
    .rd_vld         (rd_vld),
    .rd_dat         (rd_dat),
    .overflow_count (overflow_count)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      fft_samples <= '0;
      fft_start   <= 1'b0;
      bins_out    <= '0;
      bins_valid  <= 1'b0;
    end else begin
      fft_start  <= 1'b0;
      bins_valid <= 1'b0;
      case (state)
        IDLE:      if (enable && rd_vld) state <= LOAD;
        LOAD: begin
          fft_samples <= rd_dat;
          fft_start   <= 1'b1;
          state       <= START;
        end
        START:     state <= WAIT_DONE;
        WAIT_DONE: begin
          if (fft_done)       state <= CAPTURE;
          else if (wd_expire) state <= IDLE;
        end
        CAPTURE: begin
          bins_out   <= fft_bins;
          bins_valid <= 1'b1;
          state      <= IDLE;
        end
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef FFT_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wd_cnt    <= '0;
      fft_error <= 1'b0;
    end else if (state == WAIT_DONE) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire && !fft_done)
        fft_error <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  // Watchdog absent: the comparison is constant false, WAIT_DONE waits forever.
  assign wd_expire = (TIMEOUT_CYC < 0);
  assign fft_error = 1'b0;
`endif
endmodule
